// File: rtl/mod4051_residue_accum.sv
// Sequential mod-4051 accumulator for the 67 partial residues of a 400-bit operand.
// Terms arrive one per beat; the reduced sum is held with a valid/ready handshake.
module mod4051_residue_accum #(
    parameter int MOD       = 4051,
    parameter int W         = 12,
    parameter int NUM_TERMS = 67,
    parameter int CNT_W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_residue,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_residue,
    output logic         out_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               accept;
    logic               range_err;
    logic [W-1:0]       term_r;
    logic [W:0]         sum_s;
    logic [W:0]         sum_sub;
    logic [W-1:0]       acc_red;
    logic               is_final_cnt;
    logic               term_end;
    logic               term_err;
    logic               release_hs;

    assign accept    = in_valid & in_ready;
    assign range_err = (in_residue >= W'(MOD));
    // Inputs never exceed 2^W-1 < 2*MOD, so one conditional subtract fully reduces them.
    assign term_r    = range_err ? (in_residue - W'(MOD)) : in_residue;

    assign sum_s   = {1'b0, acc_q} + {1'b0, term_r};
    assign sum_sub = sum_s - (W+1)'(MOD);
    assign acc_red = (sum_s >= (W+1)'(MOD)) ? sum_sub[W-1:0] : sum_s[W-1:0];

    assign is_final_cnt = (cnt_q == CNT_W'(NUM_TERMS - 1));
    assign term_end     = accept & (in_last | is_final_cnt);
    // in_last must coincide exactly with the final term; any mismatch is a count error.
    assign term_err     = range_err | (in_last ^ is_final_cnt);
    assign release_hs   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (term_end) begin
                    state_d = S_HOLD;
                end else if (accept) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (term_end) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (release_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_ACCUM: in_ready  = 1'b1;
            S_HOLD:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (release_hs) begin
            acc_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (accept) begin
            acc_d = acc_red;
            cnt_d = cnt_q + CNT_W'(1);
            err_d = err_q | term_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // The accumulator itself is the result register; it is frozen while in HOLD.
    assign out_residue = acc_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_mod4051_residue_accum.sv
// Randomized self-checking bench for mod4051_residue_accum against an arithmetic
// reference model of whole operands (plain integer sum mod 4051).
module tb_mod4051_residue_accum;

    localparam int MOD = 4051;
    localparam int NT  = 67;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_residue;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_residue;
    logic        out_err;

    int n_cmp = 0;
    int n_err = 0;
    int vals[$];
    bit lasts[$];

    always #5 clk = ~clk;

    mod4051_residue_accum dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_residue  (in_residue),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_residue (out_residue),
        .out_err     (out_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int n, input int v, input int last_at);
        vals.delete();
        lasts.delete();
        for (int i = 0; i < n; i++) begin
            vals.push_back(v);
            lasts.push_back(i == last_at);
        end
    endtask

    // Reference: operand ends at the first in_last or at the 67th term; result is the
    // plain integer sum mod MOD; error on any out-of-range term or count mismatch.
    task automatic run_op(input string tag, input int gap_pct, input int hold_cycles);
        int  n = 0;
        int  sum = 0;
        int  exp_res;
        int  exp_err = 0;
        bit  by_last = 0;
        for (int i = 0; i < vals.size(); i++) begin
            n++;
            sum += vals[i];
            if (vals[i] >= MOD) exp_err = 1;
            if (lasts[i]) begin
                by_last = 1;
                break;
            end
            if (n == NT) break;
        end
        if (by_last && n != NT) exp_err = 1;
        if (!by_last && n == NT) exp_err = 1;
        exp_res = sum % MOD;

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) @(negedge clk);
            if (i == 0 || i == n - 1) begin
                chk({tag, "_in_ready"}, int'(in_ready), 1);
                chk({tag, "_early_valid"}, int'(out_valid), 0);
            end else if (out_valid || !in_ready) begin
                chk({tag, "_mid_handshake"}, int'({in_ready, out_valid}), 2);
            end
            in_valid   = 1'b1;
            in_residue = 12'(vals[i]);
            in_last    = lasts[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_residue"}, int'(out_residue), exp_res);
        chk({tag, "_err"}, int'(out_err), exp_err);
        chk({tag, "_hold_ready"}, int'(in_ready), 0);
        for (int c = 0; c < hold_cycles; c++) begin
            in_valid   = 1'b1;
            in_residue = 12'd5;
            @(negedge clk);
            chk({tag, "_stall_state"}, int'({in_ready, out_valid}), 1);
            chk({tag, "_stall_residue"}, int'(out_residue), exp_res);
            chk({tag, "_stall_err"}, int'(out_err), exp_err);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release"}, int'({in_ready, out_valid}), 2);
        chk({tag, "_cleared"}, int'({out_err, out_residue}), 0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_residue = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_residue", int'(out_residue), 0);
        chk("reset_err", int'(out_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        fill(NT, 4050, NT - 1);
        run_op("all4050", 0, 0);

        fill(NT, 0, NT - 1);
        vals[0] = 1;
        run_op("one_stall5", 0, 5);

        fill(3, 0, 2);
        vals[0] = 2000;
        vals[1] = 2000;
        vals[2] = 100;
        run_op("short3", 0, 1);

        fill(NT, 0, NT - 1);
        vals[0] = 4095;
        run_op("range4095", 0, 0);

        fill(1, 1234, 0);
        run_op("single", 0, 0);

        fill(NT + 3, 7, -1);
        run_op("forced_end", 0, 0);

        // Abort an operand after 30 terms with reset; nothing of it may surface.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_residue = 12'd1;
            in_last    = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_state", int'({in_ready, out_valid}), 2);
        chk("midrst_residue", int'(out_residue), 0);
        @(negedge clk);
        rst = 1'b0;
        fill(NT, 1, NT - 1);
        run_op("after_rst", 0, 0);

        fill(NT, 4000, NT - 1);
        run_op("gaps4000", 40, 2);

        for (int k = 0; k < 20; k++) begin
            int last_at;
            last_at = $urandom_range(0, 89);
            if (last_at >= NT) last_at = -1;
            fill(NT, 0, last_at);
            for (int i = 0; i < NT; i++) begin
                vals[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(MOD, 4095)
                                                      : $urandom_range(0, MOD - 1);
            end
            run_op($sformatf("rand%0d", k), 25, $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
